// File: rtl/fpu_sched_pkg.sv
// Shared types for the FP add/sub issue scheduler: FSM states, op encoding
// and the in-flight token carried alongside the external pipeline.
package fpu_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   typedef struct packed {
      logic valid;
      logic id;
   } token_t;

endpackage

// File: rtl/fpu_sched_rr_arb.sv
// Two-requester arbiter. With FPU_SCHED_RR_EN defined it rotates priority
// after every grant; otherwise requester 0 always wins and no state is kept.
module fpu_sched_rr_arb (
`ifdef FPU_SCHED_RR_EN
   input  logic       clk,
   input  logic       rst_n,
`endif
   input  logic [1:0] valid_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

`ifdef FPU_SCHED_RR_EN
   // prio_q set means requester 1 wins the next contention
   logic prio_q;

   // Grant selection with rotating priority on contention
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (valid_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
         end else begin
            gnt_o = valid_i;
         end
      end else begin
         gnt_o = 2'b00;
      end
   end

   // Priority pointer: the requester not just served goes first next time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else if (gnt_o[0]) begin
         prio_q <= 1'b1;
      end else if (gnt_o[1]) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_q;
      end
   end
`else
   // Fixed priority grant selection, requester 0 first
   always_comb begin
      gnt_o = 2'b00;
      if (en_i && valid_i[0]) begin
         gnt_o = 2'b01;
      end else if (en_i && valid_i[1]) begin
         gnt_o = 2'b10;
      end else begin
         gnt_o = 2'b00;
      end
   end
`endif

endmodule

// File: rtl/fpu_addsub_scheduler.sv
// Issues add/sub operations from two requesters into an external fixed-latency
// pipeline and returns tagged results. Arbitration mode set by FPU_SCHED_RR_EN.
module fpu_addsub_scheduler
   import fpu_sched_pkg::*;
#(
   parameter int W        = 32,
   parameter int PIPE_LAT = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic         req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic         req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic         flush,
   output logic         pipe_en,
   output logic         pipe_shift_en,
   output logic         pipe_op,
   output logic [W-1:0] pipe_a,
   output logic [W-1:0] pipe_b,
   input  logic [W-1:0] pipe_result,
   output logic         rsp_valid,
   output logic         rsp_id,
   output logic [W-1:0] rsp_result,
   output logic         busy
);

   // The response register is the last stage, so the line holds one fewer
   localparam int DEPTH = PIPE_LAT - 1;

   state_e              state_q;
   state_e              state_d;
   token_t [DEPTH-1:0]  tok_q;
   logic   [1:0]        gnt_s;
   logic                grant_en_s;
   logic                grant_s;
   logic                any_tok_s;
   logic                exit_s;
   logic                busy_d;
   logic                busy_q;
   logic                rsp_valid_q;
   logic                rsp_id_q;
   logic   [W-1:0]      rsp_result_q;

   // rst_n gates granting so ready/pipe_en drop with reset, not on the next edge
   assign grant_en_s = rst_n & ~flush & (state_q != DRAIN);
   assign grant_s    = gnt_s[0] | gnt_s[1];
   assign exit_s     = tok_q[DEPTH-1].valid & pipe_shift_en;

   fpu_sched_rr_arb u_arb (
`ifdef FPU_SCHED_RR_EN
      .clk     (clk),
      .rst_n   (rst_n),
`endif
      .valid_i ({req1_valid, req0_valid}),
      .en_i    (grant_en_s),
      .gnt_o   (gnt_s)
   );

   // Any valid token still travelling down the line
   always_comb begin
      any_tok_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         any_tok_s = any_tok_s | tok_q[i].valid;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and the busy value for the following cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_s) state_d = RUN;
            else         state_d = IDLE;
         end
         RUN: begin
            if (flush)                       state_d = DRAIN;
            else if (!grant_s && !any_tok_s) state_d = IDLE;
            else                             state_d = RUN;
         end
         DRAIN: begin
            if (!any_tok_s) state_d = IDLE;
            else            state_d = DRAIN;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE) | grant_s | any_tok_s;
   end

   // Issue-side outputs; the pipeline only advances while something is in it
   always_comb begin
      req0_ready    = gnt_s[0];
      req1_ready    = gnt_s[1];
      pipe_en       = grant_s;
      pipe_shift_en = grant_s | any_tok_s;
      if (gnt_s[1]) begin
         pipe_op = req1_op;
         pipe_a  = req1_a;
         pipe_b  = req1_b;
      end else begin
         pipe_op = req0_op;
         pipe_a  = req0_a;
         pipe_b  = req0_b;
      end
   end

   // Token line tracks ownership in lock-step with the external pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_q <= '0;
      end else if (pipe_shift_en) begin
         tok_q[0] <= token_t'{valid: grant_s, id: gnt_s[1]};
         for (int i = 1; i < DEPTH; i++) begin
            tok_q[i] <= tok_q[i-1];
         end
      end else begin
         tok_q <= tok_q;
      end
   end

   // Response and busy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= {W{1'b0}};
         busy_q       <= 1'b0;
      end else begin
         rsp_valid_q <= exit_s;
         busy_q      <= busy_d;
         if (exit_s) begin
            rsp_id_q     <= tok_q[DEPTH-1].id;
            rsp_result_q <= pipe_result;
         end else begin
            rsp_id_q     <= rsp_id_q;
            rsp_result_q <= rsp_result_q;
         end
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_addsub_scheduler.sv
// Scoreboard bench for fpu_addsub_scheduler: a behavioural model predicts grants
// and responses; a monitor checks each response against the expected queue.
module tb_fpu_addsub_scheduler;
   import fpu_sched_pkg::*;

   localparam int W        = 32;
   localparam int PIPE_LAT = 5;
   localparam int STAGES   = PIPE_LAT - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid, req0_ready, req0_op;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_op;
   logic [W-1:0] req1_a, req1_b;
   logic         flush;
   logic         pipe_en, pipe_shift_en, pipe_op;
   logic [W-1:0] pipe_a, pipe_b, pipe_result;
   logic         rsp_valid, rsp_id;
   logic [W-1:0] rsp_result;
   logic         busy;

   always #5 clk = ~clk;

   fpu_addsub_scheduler #(.W(W), .PIPE_LAT(PIPE_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .flush(flush), .pipe_en(pipe_en), .pipe_shift_en(pipe_shift_en),
      .pipe_op(pipe_op), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_result(pipe_result),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      logic         id;
      logic [W-1:0] res;
      int           due;
   } exp_t;
   exp_t sb_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Stand-in arithmetic for the external pipeline; only identity matters here
   function automatic logic [W-1:0] ref_fn(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      return (op == OP_SUB) ? a - b : a + b;
   endfunction

   // External pipeline stub that freezes when pipe_shift_en is low
   logic [W-1:0] stub_q [STAGES];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) stub_q[i] <= '0;
      end else if (pipe_shift_en) begin
         stub_q[0] <= ref_fn(pipe_op, pipe_a, pipe_b);
         for (int i = 1; i < STAGES; i++) stub_q[i] <= stub_q[i-1];
      end
   end
   assign pipe_result = stub_q[STAGES-1];

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: mode 0=idle 1=run 2=drain; issue cycles of in-flight ops
   int   m_mode;
   logic m_prio;
   logic m_busy;
   logic m_line, m_g0, m_g1, m_op;
   logic [W-1:0] m_a, m_b;
   int   m_issue[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         m_mode = 0;
         m_prio = 1'b0;
         m_busy = 1'b0;
         m_issue.delete();
      end else begin
         while (m_issue.size() > 0 && m_issue[0] + PIPE_LAT - 1 < cyc) void'(m_issue.pop_front());
         m_line = (m_issue.size() > 0);
         chk("busy", busy, m_busy);
         m_g0 = 1'b0;
         m_g1 = 1'b0;
         if (!flush && m_mode != 2) begin
            if (req0_valid && req1_valid) begin
`ifdef FPU_SCHED_RR_EN
               if (m_prio) m_g1 = 1'b1; else m_g0 = 1'b1;
`else
               m_g0 = 1'b1;
`endif
            end else begin
               m_g0 = req0_valid;
               m_g1 = req1_valid;
            end
         end
         chk("req0_ready", req0_ready, m_g0);
         chk("req1_ready", req1_ready, m_g1);
         chk("pipe_en", pipe_en, m_g0 | m_g1);
         chk("pipe_shift_en", pipe_shift_en, m_g0 | m_g1 | m_line);
         if (m_g0 || m_g1) begin
            m_op = m_g1 ? req1_op : req0_op;
            m_a  = m_g1 ? req1_a  : req0_a;
            m_b  = m_g1 ? req1_b  : req0_b;
            chk("pipe_op", pipe_op, m_op);
            chk("pipe_a", pipe_a, m_a);
            chk("pipe_b", pipe_b, m_b);
            sb_q.push_back('{id: m_g1, res: ref_fn(m_op, m_a, m_b), due: cyc + PIPE_LAT});
            m_issue.push_back(cyc);
            m_prio = m_g0;
         end
         case (m_mode)
            0: if (m_g0 || m_g1) m_mode = 1;
            1: if (flush) m_mode = 2; else if (!(m_g0 || m_g1) && !m_line) m_mode = 0;
            2: if (!m_line) m_mode = 0;
            default: m_mode = 0;
         endcase
         m_busy = (m_mode != 0) || m_g0 || m_g1 || m_line;
      end
   end

   // Monitor: every response must match the oldest expectation and its due cycle
   exp_t mon_e;
   always @(posedge clk) begin
      #2;
      if (rst_n) begin
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               chk("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("rsp_id", rsp_id, mon_e.id);
               chk("rsp_result", rsp_result, mon_e.res);
               chk("rsp_cycle", cyc, mon_e.due);
            end
         end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            chk("rsp_missing", rsp_valid, 1'b1);
         end
      end
   end

   task automatic drive(input logic v0, input logic o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic v1, input logic o1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic fl);
      req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
      flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_rsp_id"}, rsp_id, 1'b0);
      chk({tag, "_rsp_result"}, rsp_result, '0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_pipe_en"}, pipe_en, 1'b0);
      chk({tag, "_pipe_shift_en"}, pipe_shift_en, 1'b0);
      chk({tag, "_req0_ready"}, req0_ready, 1'b0);
      chk({tag, "_req1_ready"}, req1_ready, 1'b0);
   endtask

   task automatic random_traffic(input int n);
      for (int i = 0; i < n; i++) begin
         drive($urandom_range(0, 9) < 6, 1'($urandom), $urandom, $urandom,
               $urandom_range(0, 9) < 6, 1'($urandom), $urandom, $urandom,
               $urandom_range(0, 19) == 0);
      end
   endtask

   initial begin
      req0_valid = 1'b1; req0_op = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b1; req1_op = 1'b0; req1_a = '0; req1_b = '0;
      flush = 1'b0;
      #3;
      chk_reset_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // single add from requester 0
      drive(1'b1, OP_ADD, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, '0, '0, 1'b0);
      idle(8);

      // contention for four cycles
      for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom), $urandom, $urandom, 1'b1, 1'($urandom), $urandom, $urandom, 1'b0);
      idle(8);

      // three ops, then flush held with requester 1 waiting
      drive(1'b1, OP_ADD, 32'h11, 32'h22, 1'b0, 1'b0, '0, '0, 1'b0);
      drive(1'b0, 1'b0, '0, '0, 1'b1, OP_SUB, 32'h100, 32'h1, 1'b0);
      drive(1'b1, OP_SUB, 32'h5, 32'h7, 1'b0, 1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, OP_ADD, 32'h9, 32'h9, 1'b1);
      idle(3);

      // back-to-back from requester 1
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'($urandom), $urandom, $urandom, 1'b0);
      idle(8);

      random_traffic(400);
      idle(10);

      // reset two cycles after an issue discards the in-flight op
      drive(1'b1, OP_ADD, 32'hABCD, 32'h1234, 1'b0, 1'b0, '0, '0, 1'b0);
      idle(1);
      #2;
      rst_n = 1'b0;
      req0_valid = 1'b1;
      #1;
      chk_reset_outputs("midreset");
      sb_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req0_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rsp_after_reset", rsp_valid, 1'b0);
      end
      @(posedge clk);
      #1;

      random_traffic(60);
      idle(10);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
